// File: rtl/arm_controller_if.sv
// arm_controller_if
// Bundles the instruction decode fields and ALU flags going into the ARM
// control unit, together with the datapath control signals coming back out.
//   master : instruction/datapath side; drives op, cond, rd, funct, alu_flags
//            and receives the control outputs
//   slave  : the control unit itself
interface arm_controller_if;
  logic [1:0] op;
  logic [3:0] cond;
  logic [3:0] alu_flags;
  logic [3:0] rd;
  logic [5:0] funct;

  logic       pc_src;
  logic       reg_write;
  logic       mem_write;
  logic       mem_to_reg;
  logic       alu_src;
  logic       shift;
  logic [1:0] imm_src;
  logic [1:0] reg_src;
  logic [1:0] alu_ctl;

  modport master (
    output op, cond, alu_flags, rd, funct,
    input  pc_src, reg_write, mem_write, mem_to_reg, alu_src, shift,
           imm_src, reg_src, alu_ctl
  );

  modport slave (
    input  op, cond, alu_flags, rd, funct,
    output pc_src, reg_write, mem_write, mem_to_reg, alu_src, shift,
           imm_src, reg_src, alu_ctl
  );
endinterface

// File: rtl/arm_controller.sv
// arm_controller
// Control unit of the single-cycle ARM datapath. Decodes op/funct/rd into
// datapath selects and write enables, keeps the NZCV flag register, and gates
// architectural writes (register file, memory, PC, flags) by the condition
// field evaluated against the stored flags.
// Ports:
//   clk    : system clock, flag register updates on rising edge
//   reset  : synchronous active-high, clears the flag register
//   bus    : arm_controller_if.slave (decode fields in, control signals out)
// All control outputs are combinational from the inputs and stored flags.
module arm_controller (
  input  logic               clk,
  input  logic               reset,
  arm_controller_if.slave    bus
);

  typedef enum logic [3:0] {
    CMD_AND = 4'b0000,
    CMD_SUB = 4'b0010,
    CMD_ADD = 4'b0100,
    CMD_CMP = 4'b1010,
    CMD_ORR = 4'b1100,
    CMD_MOV = 4'b1101
  } cmd_e;

  typedef enum logic [3:0] {
    CC_EQ = 4'b0000, CC_NE = 4'b0001, CC_CS = 4'b0010, CC_CC = 4'b0011,
    CC_MI = 4'b0100, CC_PL = 4'b0101, CC_VS = 4'b0110, CC_VC = 4'b0111,
    CC_HI = 4'b1000, CC_LS = 4'b1001, CC_GE = 4'b1010, CC_LT = 4'b1011,
    CC_GT = 4'b1100, CC_LE = 4'b1101, CC_AL = 4'b1110, CC_NV = 4'b1111
  } cond_e;

  logic [3:0] flags;        // stored {N,Z,C,V}

  logic       branch;
  logic       reg_write_raw;
  logic       mem_write_raw;
  logic       nz_write_req;
  logic       cv_write_req;
  logic       cond_ok;
  logic       flag_n, flag_z, flag_c, flag_v;
  cmd_e       cmd;

  assign cmd = cmd_e'(bus.funct[4:1]);

  // Decode
  always_comb begin
    branch          = 1'b0;
    reg_write_raw   = 1'b0;
    mem_write_raw   = 1'b0;
    nz_write_req    = 1'b0;
    cv_write_req    = 1'b0;
    bus.mem_to_reg  = 1'b0;
    bus.alu_src     = 1'b0;
    bus.shift       = 1'b0;
    bus.imm_src     = 2'b00;
    bus.reg_src     = 2'b00;
    bus.alu_ctl     = 2'b00;

    case (bus.op)
      2'b00: begin
        bus.alu_src = bus.funct[5];
        case (cmd)
          CMD_ADD: begin bus.alu_ctl = 2'b00; reg_write_raw = 1'b1; end
          CMD_SUB: begin bus.alu_ctl = 2'b01; reg_write_raw = 1'b1; end
          CMD_AND: begin bus.alu_ctl = 2'b10; reg_write_raw = 1'b1; end
          CMD_ORR: begin bus.alu_ctl = 2'b11; reg_write_raw = 1'b1; end
          CMD_MOV: begin bus.shift   = 1'b1;  reg_write_raw = 1'b1; end
          CMD_CMP: begin bus.alu_ctl = 2'b01; end
          default: begin end
        endcase
        // CMP always updates flags even with S clear; C/V only carry meaning
        // for the arithmetic commands.
        nz_write_req = bus.funct[0] | (cmd == CMD_CMP);
        cv_write_req = nz_write_req &
                       ((cmd == CMD_ADD) | (cmd == CMD_SUB) | (cmd == CMD_CMP));
      end
      2'b01: begin
        bus.alu_src = 1'b1;
        bus.imm_src = 2'b01;
        if (bus.funct[0]) begin
          reg_write_raw  = 1'b1;
          bus.mem_to_reg = 1'b1;
        end else begin
          mem_write_raw  = 1'b1;
          bus.reg_src    = 2'b10;   // store data comes from rd on port 2
        end
      end
      2'b10: begin
        branch      = 1'b1;
        bus.alu_src = 1'b1;
        bus.imm_src = 2'b10;
        bus.reg_src = 2'b01;        // PC feeds read port 1
      end
      default: begin end
    endcase
  end

  // Condition check against the stored flags
  assign {flag_n, flag_z, flag_c, flag_v} = flags;

  always_comb begin
    cond_ok = 1'b0;
    case (cond_e'(bus.cond))
      CC_EQ: cond_ok = flag_z;
      CC_NE: cond_ok = ~flag_z;
      CC_CS: cond_ok = flag_c;
      CC_CC: cond_ok = ~flag_c;
      CC_MI: cond_ok = flag_n;
      CC_PL: cond_ok = ~flag_n;
      CC_VS: cond_ok = flag_v;
      CC_VC: cond_ok = ~flag_v;
      CC_HI: cond_ok = flag_c & ~flag_z;
      CC_LS: cond_ok = ~flag_c | flag_z;
      CC_GE: cond_ok = (flag_n == flag_v);
      CC_LT: cond_ok = (flag_n != flag_v);
      CC_GT: cond_ok = ~flag_z & (flag_n == flag_v);
      CC_LE: cond_ok = flag_z | (flag_n != flag_v);
      CC_AL: cond_ok = 1'b1;
      CC_NV: cond_ok = 1'b0;
      default: cond_ok = 1'b0;
    endcase
  end

  // Conditional gating of architectural writes
  assign bus.pc_src    = (branch | ((bus.rd == 4'd15) & reg_write_raw)) & cond_ok;
  assign bus.reg_write = reg_write_raw & cond_ok;
  assign bus.mem_write = mem_write_raw & cond_ok;

  // Flag register; the writing instruction is checked against the old flags
  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= 4'b0000;
    end else begin
      if (nz_write_req & cond_ok) flags[3:2] <= bus.alu_flags[3:2];
      if (cv_write_req & cond_ok) flags[1:0] <= bus.alu_flags[1:0];
    end
  end

endmodule

// File: tb/tb_arm_controller.sv
// Testbench for arm_controller: a driver issues instructions (directed, then
// random), a reference model predicts the control outputs and pushes them
// into a queue, and a monitor on the falling edge pops and compares.
module tb_arm_controller;

  logic clk;
  logic reset;

  arm_controller_if bus ();

  arm_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_src;
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       shift;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
    logic [1:0] alu_ctl;
  } ctl_t;

  ctl_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: flags as the architecture defines them, plus the effect of
  // the instruction currently in flight (applied at the next rising edge).
  logic [3:0] m_flags;
  logic       pend_rst;
  logic       pend_nz;
  logic       pend_cv;
  logic [3:0] pend_af;

  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cf && !z;
      4'd9:  return !cf || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Instruction-level reference: what each instruction class asks of the
  // datapath, then the condition applied to the writes.
  task automatic model(input logic [1:0] o, input logic [3:0] c, input logic [3:0] r,
                       input logic [5:0] f, input logic [3:0] fl,
                       output ctl_t e, output logic nz, output logic cv);
    logic wants_reg, wants_mem, is_branch, pass;
    int   kind;          // 0 ADD 1 SUB 2 AND 3 ORR 4 MOV 5 CMP 6 other
    e = '0; nz = 0; cv = 0;
    wants_reg = 0; wants_mem = 0; is_branch = 0;
    pass = cond_holds(c, fl);
    if (o == 2'd0) begin
      e.alu_src = f[5];
      kind = (f[4:1] == 4'd4)  ? 0 : (f[4:1] == 4'd2)  ? 1 :
             (f[4:1] == 4'd0)  ? 2 : (f[4:1] == 4'd12) ? 3 :
             (f[4:1] == 4'd13) ? 4 : (f[4:1] == 4'd10) ? 5 : 6;
      if (kind == 1 || kind == 5) e.alu_ctl = 2'd1;
      if (kind == 2) e.alu_ctl = 2'd2;
      if (kind == 3) e.alu_ctl = 2'd3;
      e.shift   = (kind == 4);
      wants_reg = (kind <= 4);
      nz = f[0] || kind == 5;
      cv = nz && (kind == 0 || kind == 1 || kind == 5);
    end else if (o == 2'd1) begin
      e.alu_src = 1; e.imm_src = 2'd1;
      if (f[0]) begin wants_reg = 1; e.mem_to_reg = 1; end
      else begin wants_mem = 1; e.reg_src = 2'd2; end
    end else if (o == 2'd2) begin
      is_branch = 1; e.alu_src = 1; e.imm_src = 2'd2; e.reg_src = 2'd1;
    end
    e.reg_write = wants_reg && pass;
    e.mem_write = wants_mem && pass;
    e.pc_src    = (is_branch || (wants_reg && r == 4'd15)) && pass;
    nz = nz && pass;
    cv = cv && pass;
  endtask

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so every issued instruction has a
  // response by the falling edge of its cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ctl_t e;
      e = exp_q.pop_front();
      chk("pc_src",     {1'b0, bus.pc_src},     {1'b0, e.pc_src});
      chk("reg_write",  {1'b0, bus.reg_write},  {1'b0, e.reg_write});
      chk("mem_write",  {1'b0, bus.mem_write},  {1'b0, e.mem_write});
      chk("mem_to_reg", {1'b0, bus.mem_to_reg}, {1'b0, e.mem_to_reg});
      chk("alu_src",    {1'b0, bus.alu_src},    {1'b0, e.alu_src});
      chk("shift",      {1'b0, bus.shift},      {1'b0, e.shift});
      chk("imm_src",    bus.imm_src,            e.imm_src);
      chk("reg_src",    bus.reg_src,            e.reg_src);
      chk("alu_ctl",    bus.alu_ctl,            e.alu_ctl);
    end
  end

  task automatic issue(input logic [1:0] o, input logic [3:0] c, input logic [3:0] r,
                       input logic [5:0] f, input logic [3:0] af, input logic rst);
    ctl_t e;
    logic nz, cv;
    @(posedge clk);
    #1;
    if (pend_rst) m_flags = 4'b0000;
    else begin
      if (pend_nz) m_flags[3:2] = pend_af[3:2];
      if (pend_cv) m_flags[1:0] = pend_af[1:0];
    end
    bus.op = o; bus.cond = c; bus.rd = r; bus.funct = f; bus.alu_flags = af;
    reset = rst;
    model(o, c, r, f, m_flags, e, nz, cv);
    exp_q.push_back(e);
    pend_rst = rst; pend_nz = nz; pend_cv = cv; pend_af = af;
  endtask

  initial begin
    reset = 1'b1;
    bus.op = 2'd0; bus.cond = 4'd0; bus.rd = 4'd0; bus.funct = 6'd0; bus.alu_flags = 4'd0;
    m_flags = 4'b0000;
    pend_rst = 1'b1; pend_nz = 1'b0; pend_cv = 1'b0; pend_af = 4'd0;

    // Hold reset one more cycle; decode outputs are still live during it
    issue(2'b10, 4'hE, 4'd0, 6'b000000, 4'h0, 1'b1);
    // Branch and AND
    issue(2'b10, 4'hE, 4'd0, 6'b000000, 4'h0, 1'b0);
    issue(2'b00, 4'hE, 4'd0, 6'b000000, 4'h0, 1'b0);
    // Memory STR / LDR
    issue(2'b01, 4'hE, 4'd0, 6'b000000, 4'h0, 1'b0);
    issue(2'b01, 4'hE, 4'd0, 6'b000001, 4'h0, 1'b0);
    // ALU decode
    issue(2'b00, 4'hE, 4'd1, 6'b001000, 4'h0, 1'b0);
    issue(2'b00, 4'hE, 4'd1, 6'b000100, 4'h0, 1'b0);
    issue(2'b00, 4'hE, 4'd1, 6'b000000, 4'h0, 1'b0);
    issue(2'b00, 4'hE, 4'd1, 6'b011000, 4'h0, 1'b0);
    issue(2'b00, 4'hE, 4'd1, 6'b011010, 4'h0, 1'b0);
    // Flags still 0000: EQ-gated LDR / STR suppressed
    issue(2'b01, 4'h0, 4'd2, 6'b000001, 4'h0, 1'b0);
    issue(2'b01, 4'h0, 4'd2, 6'b000000, 4'h0, 1'b0);
    // SUBS sets Z, then EQ passes and NE fails
    issue(2'b00, 4'hE, 4'd3, 6'b000101, 4'b0100, 1'b0);
    issue(2'b01, 4'h0, 4'd2, 6'b000000, 4'h0, 1'b0);
    issue(2'b01, 4'h1, 4'd2, 6'b000000, 4'h0, 1'b0);
    // ADD to PC
    issue(2'b00, 4'hE, 4'd15, 6'b001000, 4'h0, 1'b0);
    // Undefined op
    issue(2'b11, 4'hE, 4'd15, 6'b111111, 4'hF, 1'b0);
    // CMP with S clear still writes flags (N and V set -> GE passes)
    issue(2'b00, 4'hE, 4'd0, 6'b010100, 4'b1001, 1'b0);
    issue(2'b10, 4'hA, 4'd0, 6'b000000, 4'h0, 1'b0);
    issue(2'b10, 4'hB, 4'd0, 6'b000000, 4'h0, 1'b0);
    // Mid-run reset clears flags: EQ fails afterwards
    issue(2'b00, 4'hE, 4'd3, 6'b000101, 4'b0100, 1'b0);
    issue(2'b00, 4'hE, 4'd0, 6'b000000, 4'h0, 1'b1);
    issue(2'b01, 4'h0, 4'd2, 6'b000000, 4'h0, 1'b0);
    issue(2'b01, 4'h1, 4'd2, 6'b000000, 4'h0, 1'b0);

    // Random instructions, biased toward data-processing with S so that
    // flags move often, with occasional resets
    for (int i = 0; i < 600; i++) begin
      logic [1:0] o;
      logic [5:0] f;
      o = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      f = 6'($urandom);
      if (o == 2'd0 && $urandom_range(0, 2) != 0) begin
        case ($urandom_range(0, 5))
          0: f[4:1] = 4'd4;
          1: f[4:1] = 4'd2;
          2: f[4:1] = 4'd0;
          3: f[4:1] = 4'd12;
          4: f[4:1] = 4'd13;
          default: f[4:1] = 4'd10;
        endcase
      end
      issue(o, 4'($urandom), ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom),
            f, 4'($urandom), ($urandom_range(0, 40) == 0));
    end

    // Drain the scoreboard, bounded
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
